// File: rtl/axil_reg_slave.sv
// AXI-Lite register slave: byte-strobed register bank behind
// single-entry AW/W buffers, with per-register write pulses.
module axil_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS);

   logic                  aw_full;
   logic [ADDR_WIDTH-1:0] aw_idx;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]     w_strb;
   logic                  rd_busy;
   logic                  rd_ok;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  commit;
   logic                  wr_ok;
   logic [IDX_W-1:0]      wr_idx;
   logic [ADDR_WIDTH-1:0] ar_idx;

   assign awready = ~aw_full;
   assign wready  = ~w_full;
   assign arready = ~rd_busy;

   // Full shifted address is range-checked so aliases above NUM_REGS miss.
   assign commit = aw_full & w_full & ~bvalid;
   assign wr_ok  = aw_idx < LIMIT;
   assign wr_idx = aw_idx[IDX_W-1:0];
   assign ar_idx = araddr >> OFFS;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_full <= 1'b0;
         aw_idx  <= '0;
      end else if (awvalid && !aw_full) begin
         aw_full <= 1'b1;
         aw_idx  <= awaddr >> OFFS;
      end else if (commit) begin
         aw_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_full <= 1'b0;
         w_data <= '0;
         w_strb <= '0;
      end else if (wvalid && !w_full) begin
         w_full <= 1'b1;
         w_data <= wdata;
         w_strb <= wstrb;
      end else if (commit) begin
         w_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bvalid     <= 1'b0;
         wr_pulse_o <= '0;
      end else begin
         wr_pulse_o <= '0;
         if (commit) begin
            bvalid <= 1'b1;
            if (wr_ok) wr_pulse_o[wr_idx] <= 1'b1;
         end else if (bready) begin
            bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit && wr_ok) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (w_strb[k]) regs[wr_idx][k*8 +: 8] <= w_data[k*8 +: 8];
         end
      end
   end

   // rdata samples regs before any same-edge commit lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_busy <= 1'b0;
         rd_ok   <= 1'b0;
         rd_idx  <= '0;
         rvalid  <= 1'b0;
         rdata   <= '0;
      end else if (arvalid && !rd_busy) begin
         rd_busy <= 1'b1;
         rd_ok   <= ar_idx < LIMIT;
         rd_idx  <= ar_idx[IDX_W-1:0];
      end else if (rd_busy && !rvalid) begin
         rvalid <= 1'b1;
         rdata  <= rd_ok ? regs[rd_idx] : '0;
      end else if (rvalid && rready) begin
         rvalid  <= 1'b0;
         rd_busy <= 1'b0;
      end
   end

endmodule
